shift_add_mult_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 14 +
 rtl/shift_add_mult_ctrl_if.sv | 27 ++
 rtl/rca_comb.sv | 42 ++++
 rtl/shift_add_mult_ctrl.sv | 132 +++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the shift-add multiplier controller.
// Sizing must keep 2**CNT_W > WIDTH so the iteration counter can reach WIDTH-1.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// start/ready/done handshake plus operand and product buses for the multiplier.
// The source/consumer side uses master; the multiplier uses slave.
interface shift_add_mult_ctrl_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );

endinterface

// File: rtl/rca_comb.sv
// Purely combinational N-bit ripple-carry adder built from full-adder cells.
// No state lives here; the controller owns every register.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

module rca_comb #(
    parameter int N = 17
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);

    logic [N:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .x  (A[i]),
            .y  (B[i]),
            .ci (carry[i]),
            .s  (S[i]),
            .co (carry[i+1])
        );
    end

    assign Cout = carry[N];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-add multiplier: WIDTH add/shift iterations on one ripple adder.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand jumps straight from IDLE to DONE.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_add_mult_ctrl_if.slave  bus
);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplr;
    logic [WIDTH:0]       acc;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic                 cout;
    logic                 last_iter;
    logic                 accept;
    logic                 ready_c;
    logic                 busy_c;
    logic                 done_c;

`ifdef MULT_ZERO_SKIP_EN
    logic                 zero_op;
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`endif

    assign addend    = mplr[0] ? mcand : '0;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // acc[WIDTH] is always zero going in, so Cout is the (zero) bit shifted into acc's top.
    rca_comb #(
        .N (WIDTH + 1)
    ) u_rca (
        .A    (acc),
        .B    ({1'b0, addend}),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    accept = 1'b1;
`ifdef MULT_ZERO_SKIP_EN
                    state_next = zero_op ? DONE : RUN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The sum's carry lands in the top product bit via the shift, so no carry is ever dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= bus.a;
                        mplr  <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
`ifdef MULT_ZERO_SKIP_EN
                        if (zero_op) begin
                            product_q <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    acc  <= {cout, sum[WIDTH:1]};
                    mplr <= {sum[0], mplr[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        product_q <= {sum, mplr[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = ready_c;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed cases plus random operands
// compared against a plain a*b reference; zero-skip latency follows MULT_ZERO_SKIP_EN.
module tb_shift_add_mult_ctrl;
    import mult_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;
    localparam int CNT_W = DEFAULT_CNT_W;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   failures = 0;
    int   cycle = 0;
    int   done_cycle = 0;
    logic [2*WIDTH-1:0] last_product = '0;

    shift_add_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

    shift_add_mult_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int expected_latency(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
`ifdef MULT_ZERO_SKIP_EN
        if (op_a == '0 || op_b == '0) return 1;
`endif
        return WIDTH + 1;
    endfunction

    // Called at a negedge with ready=1; leaves the bench at the negedge after the done cycle.
    task automatic apply_stimulus(input string tag, input logic [WIDTH-1:0] op_a,
                                  input logic [WIDTH-1:0] op_b, input int inject_at);
        logic [2*WIDTH-1:0] exp_prod;
        int lat;
        exp_prod = (2*WIDTH)'(64'(op_a) * 64'(op_b));
        bus.start = 1'b1;
        bus.a     = op_a;
        bus.b     = op_b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        lat = 0;
        for (int k = 1; k <= 3 * WIDTH && lat == 0; k++) begin
            if (bus.done === 1'b1) begin
                lat        = k;
                done_cycle = cycle;
            end else begin
                check_output({tag, " ready low in run"}, bus.ready, 0);
                check_output({tag, " busy in run"}, bus.busy, 1);
                check_output({tag, " product held"}, bus.product, last_product);
                bus.start = (k == inject_at);
                if (k == inject_at) begin
                    bus.a = 2;
                    bus.b = 2;
                end
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        check_output({tag, " latency"}, lat, expected_latency(op_a, op_b));
        check_output({tag, " product"}, bus.product, exp_prod);
        check_output({tag, " ready low in done"}, bus.ready, 0);
        last_product = exp_prod;
        @(negedge clk);
        check_output({tag, " done one cycle"}, bus.done, 0);
        check_output({tag, " ready after done"}, bus.ready, 1);
    endtask

    initial begin
        int prev_done;
        int done_count;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check_output("reset ready", bus.ready, 1);
        check_output("reset busy", bus.busy, 0);
        check_output("reset done", bus.done, 0);
        check_output("reset product", bus.product, 0);
        reset = 1'b0;
        @(negedge clk);

        apply_stimulus("basic 3x5", 16'd3, 16'd5, 0);
        check_output("basic value", bus.product, 32'h0000_000F);

        apply_stimulus("max operands", 16'hFFFF, 16'hFFFF, 0);
        check_output("max value", bus.product, 32'hFFFE_0001);

        // A start driven mid-run must be ignored; the run's only done comes from the 7x9 job.
        apply_stimulus("start while busy", 16'd7, 16'd9, 5);
        check_output("busy value", bus.product, 32'h0000_003F);
        done_count = 0;
        repeat (2 * WIDTH) begin
            if (bus.done === 1'b1) done_count++;
            @(negedge clk);
        end
        check_output("busy no second done", done_count, 0);

        // Reset in the middle of a run aborts it without a done pulse.
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_output("abort ready", bus.ready, 1);
        check_output("abort busy", bus.busy, 0);
        check_output("abort done", bus.done, 0);
        check_output("abort product", bus.product, 0);
        last_product = '0;
        done_count = 0;
        repeat (2 * WIDTH) begin
            if (bus.done === 1'b1) done_count++;
            @(negedge clk);
        end
        check_output("abort no done", done_count, 0);
        apply_stimulus("after abort", 16'h1234, 16'h5678, 0);
        check_output("after abort value", bus.product, 32'h0626_0060);

        apply_stimulus("b2b first", 16'h00FF, 16'h0101, 0);
        prev_done = done_cycle;
        apply_stimulus("b2b second", 16'h8000, 16'h0002, 0);
        check_output("b2b value", bus.product, 32'h0001_0000);
        check_output("b2b spacing", done_cycle - prev_done, WIDTH + 2);

        apply_stimulus("zero a", 16'h0000, 16'hABCD, 0);
        check_output("zero value", bus.product, 0);

        for (int i = 0; i < 10; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (i == 3) ra = '0;
            if (i == 6) rb = '0;
            apply_stimulus($sformatf("random %0d", i), ra, rb, (i % 4 == 1) ? 3 + i : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
